// File: rtl/fib_chk_pkg.sv
// Shared constants for the Fibonacci retirement checker: FSM encoding,
// failure cause codes and the trace-entry width helper.
package fib_chk_pkg;

  localparam int unsigned INSTR_W   = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned STATE_W   = 2;
  localparam int unsigned CAUSE_W   = 2;
  localparam int unsigned TERM_W    = 16;
  localparam int unsigned CYCLE_W   = 32;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;
  localparam logic [STATE_W-1:0] ST_FAIL = 2'd3;

  typedef enum logic [CAUSE_W-1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISMATCH = 2'd1,
    CAUSE_HALT     = 2'd2,
    CAUSE_TIMEOUT  = 2'd3
  } fail_cause_e;

  // One trace entry is {pc, instr, wb data}.
  function automatic int unsigned trace_entry_w(input int unsigned pc_w,
                                                input int unsigned data_w);
    return pc_w + INSTR_W + data_w;
  endfunction

endpackage

// File: rtl/fib_trace_checker_if.sv
// Retirement/write-back input bundle plus trace read port and verdict outputs.
interface fib_trace_checker_if
  import fib_chk_pkg::*;
#(
  parameter int unsigned PC_W     = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned TRACE_AW = 4
);

  logic                  retire_valid;
  logic [PC_W-1:0]       retire_pc;
  logic [INSTR_W-1:0]    retire_instr;
  logic                  wb_en;
  logic [REG_IDX_W-1:0]  wb_reg;
  logic [DATA_W-1:0]     wb_data;
  logic [TRACE_AW-1:0]   rd_idx;

  logic [PC_W-1:0]       rd_pc;
  logic [INSTR_W-1:0]    rd_instr;
  logic [DATA_W-1:0]     rd_data;
  logic [TRACE_AW:0]     trace_count;
  logic [CYCLE_W-1:0]    cycle_count;
  logic [TERM_W-1:0]     term_count;
  logic [STATE_W-1:0]    state;
  logic [CAUSE_W-1:0]    fail_cause;
  logic [PC_W-1:0]       fail_pc;
  logic [DATA_W-1:0]     fail_expected;
  logic [DATA_W-1:0]     fail_actual;

  modport master (
    output retire_valid, retire_pc, retire_instr, wb_en, wb_reg, wb_data, rd_idx,
    input  rd_pc, rd_instr, rd_data, trace_count, cycle_count, term_count,
           state, fail_cause, fail_pc, fail_expected, fail_actual
  );

  modport slave (
    input  retire_valid, retire_pc, retire_instr, wb_en, wb_reg, wb_data, rd_idx,
    output rd_pc, rd_instr, rd_data, trace_count, cycle_count, term_count,
           state, fail_cause, fail_pc, fail_expected, fail_actual
  );

endinterface

// File: rtl/fib_trace_checker_ring.sv
// Circular trace store with a write port and an oldest-relative combinational
// read port; owns the write pointer and the saturating valid-entry count.
module trace_ring_buffer #(
  parameter  int unsigned TRACE_DEPTH = 16,
  parameter  int unsigned ENTRY_W     = 96,
  localparam int unsigned AW          = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_entry,
  input  logic [AW-1:0]      rd_idx,
  output logic [ENTRY_W-1:0] rd_entry,
  output logic [AW:0]        count
);

  logic [ENTRY_W-1:0] mem [TRACE_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_phys;

  // Pointer wraps naturally because the depth is a power of two.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      count  <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (count != (AW+1)'(TRACE_DEPTH))
        count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_entry;
  end

  // A full count of TRACE_DEPTH truncates to 0, which is the right offset mod depth.
  assign rd_phys  = wr_ptr - count[AW-1:0] + rd_idx;
  assign rd_entry = mem[rd_phys];

endmodule

// File: rtl/fib_trace_checker.sv
// Retirement monitor: traces retired instructions and checks write-backs to
// CHECK_REG against a Fibonacci generator. Optional watchdog: FIB_CHECK_TIMEOUT_EN.
module fib_trace_checker
  import fib_chk_pkg::*;
#(
  parameter int unsigned          PC_W        = 32,
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          TRACE_DEPTH = 16,
  parameter int unsigned          TRACE_AW    = $clog2(TRACE_DEPTH),
  parameter logic [REG_IDX_W-1:0] CHECK_REG   = 5'd10,
  parameter int unsigned          NUM_TERMS   = 12,
  parameter int unsigned          HALT_REPEAT = 4
`ifdef FIB_CHECK_TIMEOUT_EN
  ,
  parameter int unsigned          MAX_CYCLES  = 1000
`endif
) (
  input logic               clk,
  input logic               reset,
  fib_trace_checker_if.slave bus
);

  localparam int unsigned ENTRY_W = trace_entry_w(PC_W, DATA_W);
  localparam int unsigned REP_W   = $clog2(HALT_REPEAT + 1);

  logic [STATE_W-1:0] state_q,    state_d;
  logic [CYCLE_W-1:0] cycle_q,    cycle_d;
  logic [TERM_W-1:0]  term_q,     term_d;
  logic [DATA_W-1:0]  fib_a_q,    fib_a_d;
  logic [DATA_W-1:0]  fib_b_q,    fib_b_d;
  logic [REP_W-1:0]   rep_q,      rep_d;
  logic [PC_W-1:0]    prev_pc_q,  prev_pc_d;
  logic               prev_vld_q, prev_vld_d;
  logic [CAUSE_W-1:0] cause_q,    cause_d;
  logic [PC_W-1:0]    fpc_q,      fpc_d;
  logic [DATA_W-1:0]  fexp_q,     fexp_d;
  logic [DATA_W-1:0]  fact_q,     fact_d;

  logic               active;
  logic               retire;
  logic               check;
  logic               mismatch;
  logic               good;
  logic               halt;
  logic               done;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;
  logic [TRACE_AW:0]  trace_count;

  // Only IDLE and RUN accept retires; DONE/FAIL freeze everything.
  assign active   = (state_q == ST_IDLE) || (state_q == ST_RUN);
  assign retire   = active && bus.retire_valid;
  assign check    = retire && bus.wb_en && (bus.wb_reg == CHECK_REG);
  assign mismatch = check && (bus.wb_data != fib_a_q);
  assign good     = check && !mismatch;
  assign wr_entry = {bus.retire_pc, bus.retire_instr, bus.wb_en ? bus.wb_data : DATA_W'(0)};

  trace_ring_buffer #(
    .TRACE_DEPTH (TRACE_DEPTH),
    .ENTRY_W     (ENTRY_W)
  ) u_ring (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (retire),
    .wr_entry (wr_entry),
    .rd_idx   (bus.rd_idx),
    .rd_entry (rd_entry),
    .count    (trace_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cycle_q    <= '0;
      term_q     <= '0;
      fib_a_q    <= '0;
      fib_b_q    <= DATA_W'(1);
      rep_q      <= '0;
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
      cause_q    <= CAUSE_NONE;
      fpc_q      <= '0;
      fexp_q     <= '0;
      fact_q     <= '0;
    end else begin
      state_q    <= state_d;
      cycle_q    <= cycle_d;
      term_q     <= term_d;
      fib_a_q    <= fib_a_d;
      fib_b_q    <= fib_b_d;
      rep_q      <= rep_d;
      prev_pc_q  <= prev_pc_d;
      prev_vld_q <= prev_vld_d;
      cause_q    <= cause_d;
      fpc_q      <= fpc_d;
      fexp_q     <= fexp_d;
      fact_q     <= fact_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cycle_d    = cycle_q;
    term_d     = term_q;
    fib_a_d    = fib_a_q;
    fib_b_d    = fib_b_q;
    rep_d      = rep_q;
    prev_pc_d  = prev_pc_q;
    prev_vld_d = prev_vld_q;
    cause_d    = cause_q;
    fpc_d      = fpc_q;
    fexp_d     = fexp_q;
    fact_d     = fact_q;
    halt       = 1'b0;
    done       = 1'b0;

    if (state_q == ST_RUN && cycle_q != '1)
      cycle_d = cycle_q + 1'b1;

    // Golden generator advances only on a correct term; wrap is legal.
    if (good) begin
      term_d  = term_q + 1'b1;
      fib_a_d = fib_b_q;
      fib_b_d = fib_a_q + fib_b_q;
    end

    // Run length of identical consecutive retire PCs (branch-to-self).
    if (retire) begin
      if (prev_vld_q && bus.retire_pc == prev_pc_q)
        rep_d = (rep_q == '1) ? rep_q : rep_q + 1'b1;
      else
        rep_d = '0;
      prev_pc_d  = bus.retire_pc;
      prev_vld_d = 1'b1;
      halt = (rep_d == REP_W'(HALT_REPEAT - 1)) && (term_d < TERM_W'(NUM_TERMS));
    end

    done = good && (term_d == TERM_W'(NUM_TERMS));

    if (retire && state_q == ST_IDLE)
      state_d = ST_RUN;

    // Priority: mismatch, then halt, then pass, then watchdog.
    if (mismatch) begin
      state_d = ST_FAIL;
      cause_d = CAUSE_MISMATCH;
      fpc_d   = bus.retire_pc;
      fexp_d  = fib_a_q;
      fact_d  = bus.wb_data;
    end else if (halt) begin
      state_d = ST_FAIL;
      cause_d = CAUSE_HALT;
      fpc_d   = bus.retire_pc;
      fexp_d  = fib_a_q;
      fact_d  = '0;
    end else if (done) begin
      state_d = ST_DONE;
    end
`ifdef FIB_CHECK_TIMEOUT_EN
    else if (state_q == ST_RUN && cycle_d == CYCLE_W'(MAX_CYCLES)) begin
      state_d = ST_FAIL;
      cause_d = CAUSE_TIMEOUT;
      fpc_d   = retire ? bus.retire_pc : prev_pc_q;
      fexp_d  = fib_a_q;
      fact_d  = '0;
    end
`endif
  end

  assign bus.rd_pc         = rd_entry[ENTRY_W-1 -: PC_W];
  assign bus.rd_instr      = rd_entry[DATA_W +: INSTR_W];
  assign bus.rd_data       = rd_entry[DATA_W-1:0];
  assign bus.trace_count   = trace_count;
  assign bus.cycle_count   = cycle_q;
  assign bus.term_count    = term_q;
  assign bus.state         = state_q;
  assign bus.fail_cause    = cause_q;
  assign bus.fail_pc       = fpc_q;
  assign bus.fail_expected = fexp_q;
  assign bus.fail_actual   = fact_q;

endmodule

// File: doc/fib_trace_checker.md
Name: fib_trace_checker

Overview:
- Parametrised, synthesizable retirement monitor that sits beside the single-cycle MIPS core.
- Records a circular trace of retired instructions (PC, instruction, write-back data).
- Checks write-backs to one designated register against an internally generated Fibonacci sequence.
- Reports pass, fail or timeout through a small state machine; replaces eyeballing $monitor output with a self-checking, on-chip-capable verdict.

Parameters:
- PC_W, 32, width of retire_pc.
- DATA_W, 32, width of write-back data and of the golden generator.
- TRACE_DEPTH, 16, trace entries; must be a power of two ≥ 2.
- TRACE_AW, $clog2(TRACE_DEPTH), trace address width.
- CHECK_REG, 5'd10, register index whose write-backs are checked.
- NUM_TERMS, 12, Fibonacci terms required for pass.
- HALT_REPEAT, 4, consecutive same-PC retires treated as a halt (branch-to-self).
- MAX_CYCLES, 1000, watchdog limit in clk cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- retire_valid  in  1  one instruction completes this cycle.
- retire_pc  in  PC_W  PC of the retiring instruction.
- retire_instr  in  32  instruction word.
- wb_en  in  1  register-file write this cycle.
- wb_reg  in  5  destination register index.
- wb_data  in  DATA_W  value written.
- rd_idx  in  TRACE_AW  trace read index; 0 = oldest valid entry.
- rd_pc  out  PC_W  trace read data, combinational from rd_idx.
- rd_instr  out  32  trace read data, combinational from rd_idx.
- rd_data  out  DATA_W  trace read data, combinational from rd_idx.
- trace_count  out  TRACE_AW+1  valid entries; saturates at TRACE_DEPTH.
- cycle_count  out  32  clk cycles spent in RUN.
- term_count  out  16  Fibonacci terms checked OK.
- state  out  2  IDLE=0, RUN=1, DONE=2, FAIL=3.
- fail_cause  out  2  NONE=0, MISMATCH=1, HALT=2, TIMEOUT=3.
- fail_pc  out  PC_W  PC at the first failure.
- fail_expected  out  DATA_W  expected value at the first failure.
- fail_actual  out  DATA_W  actual value at the first failure.

Behaviour:
- Reset (asynchronous, active-high) gives:
  - state=IDLE; all counters 0; fail_* 0.
  - Golden generator a=0, b=1.
  - Trace write pointer 0, trace_count 0.
  - Trace RAM contents need no reset; reads of indices ≥ trace_count return don't-care.
- IDLE→RUN on the first retire_valid. That retire is itself traced and checked in the same cycle.
- RUN, every cycle: cycle_count += 1, saturating at 2^32-1.
- RUN, each retire_valid:
  - Write {pc, instr, wb_en ? wb_data : 0} at wr_ptr; wr_ptr wraps mod TRACE_DEPTH.
  - trace_count += 1 until it reaches TRACE_DEPTH.
  - Read mapping: physical = (wr_ptr − trace_count + rd_idx) mod TRACE_DEPTH.
- Check event = retire_valid & wb_en & wb_reg==CHECK_REG.
  - If wb_data==a: term_count += 1; a←b; b←a+b, truncated mod 2^DATA_W (wrap is not an error).
  - Otherwise: FAIL with cause MISMATCH; fail_expected=a, fail_actual=wb_data.
- Halt detection: repeat counter increments when retire_pc equals the previous retire_pc and clears otherwise.
  - When the counter reaches HALT_REPEAT−1 (i.e. HALT_REPEAT identical PCs) with term_count < NUM_TERMS → FAIL, cause HALT.
- term_count reaching NUM_TERMS → DONE.
- Same-cycle events:
  - Mismatch beats halt, which beats DONE.
  - A correct final term together with a halt in the same cycle → DONE.
- DONE and FAIL are terminal until reset.
  - Trace is frozen in both states: no writes, counters held.
  - fail_* capture only the first failure.
- No new state is entered between retire events; all outputs are registered except the trace read data.

Optional Feature:
- Macro FIB_CHECK_TIMEOUT_EN.
- Defined: in RUN, cycle_count reaching MAX_CYCLES with state not yet DONE → FAIL, cause TIMEOUT.
  - fail_pc = last retired PC; fail_expected = a; fail_actual = 0.
  - A mismatch or halt in the same cycle takes priority over TIMEOUT.
- Undefined: no watchdog logic; cause code 3 is never produced; MAX_CYCLES is ignored.

Decomposition:
- Package fib_chk_pkg holds:
  - State encoding constants.
  - fail_cause codes.
  - Trace-entry width helper function.
- One sub-module, trace_ring_buffer (parameters TRACE_DEPTH, entry width):
  - Write port plus combinational oldest-relative read port.
  - Owns wr_ptr and trace_count.
- The FSM, golden generator and halt detector stay in the top.

Test Plan:
- Reset, then retire 12 correct write-backs to r10 (0,1,1,2,3,5,8,13,21,34,55,89) → state=DONE, term_count=12, fail_cause=0.
- 5th check writes 4 instead of 3 → FAIL, fail_cause=1, fail_expected=3, fail_actual=4, fail_pc = that retire's PC; state and counters stay frozen afterwards.
- After 3 good terms, retire PC 0x40 four times consecutively → FAIL, fail_cause=2, fail_pc=0x40.
- Retire 20 instructions with PCs 0,4,…,76 and TRACE_DEPTH=16 → trace_count=16; rd_idx=0 gives pc=16, rd_idx=15 gives pc=76.
- Write-backs to r9 and r11 with arbitrary data → ignored; term_count unchanged.
- Assert reset mid-RUN → all outputs return to reset values immediately, without waiting for a clock edge.
- With FIB_CHECK_TIMEOUT_EN and MAX_CYCLES=50, no check events → FAIL, fail_cause=3 at cycle_count=50.
